// File: rtl/param_binary_counter.sv
// Modulo-N up/down counter with LS161-style ENP/ENT/RCO cascading, synchronous clear,
// range-checked parallel load, and registered compare-match and wrap flags.
module param_binary_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             sclr_i,
  input  logic             load_n_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             enp_i,
  input  logic             ent_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic [WIDTH-1:0] q_o,
  output logic             rco_o,
  output logic             match_o,
  output logic             wrap_o,
  output logic             ld_err_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH is representable in the range checks.
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;

  logic             tc;
  logic             count_en;
  logic             d_valid;
  logic             cmp_valid;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;

  always_comb begin
    tc        = up_i ? (q_q == MaxVal) : (q_q == '0);
    count_en  = enp_i & ent_i;
    d_valid   = {1'b0, d_i} < ModExt;
    cmp_valid = {1'b0, cmp_i} < ModExt;
    q_inc     = (q_q == MaxVal) ? '0 : q_q + 1'b1;
    q_dec     = (q_q == '0) ? MaxVal : q_q - 1'b1;
  end

  always_comb begin
    q_d      = q_q;
    wrap_d   = 1'b0;
    ld_err_d = ld_err_q;
    if (sclr_i) begin
      q_d      = RstVal;
      ld_err_d = 1'b0;
    end else if (!load_n_i) begin
      if (d_valid) begin
        q_d = d_i;
      end else begin
        q_d      = MaxVal;
        ld_err_d = 1'b1;
      end
    end else if (count_en) begin
      q_d    = up_i ? q_inc : q_dec;
      wrap_d = tc;
    end
    // Compare against the next value so MATCH lines up with the Q it describes.
    match_d = cmp_valid & (q_d == cmp_i);
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      q_q      <= RstVal;
      match_q  <= 1'b0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      match_q  <= match_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign q_o      = q_q;
  assign rco_o    = ent_i & tc;
  assign match_o  = match_q;
  assign wrap_o   = wrap_q;
  assign ld_err_o = ld_err_q;

endmodule

// File: tb/tb_param_binary_counter.sv
// Bench for param_binary_counter: directed scenarios plus random stimulus against an
// arithmetic reference model for a mod-10, a mod-5 and a cascaded 8-bit configuration.
module tb_param_binary_counter;

  typedef struct {
    int q;
    int match;
    int wrap;
    int err;
  } st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b0;
  logic       sclr, load_n, enp, ent, up;
  logic [3:0] d_a, cmp_a;
  logic [2:0] d_b, cmp_b;
  logic       c_sclr, c_load_n, c_enp, c_ent, c_up;
  logic [7:0] c_d, c_cmp;

  logic [3:0] q_a;
  logic       rco_a, match_a, wrap_a, err_a;
  logic [2:0] q_b;
  logic       rco_b, match_b, wrap_b, err_b;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, hi_rco, lo_match, hi_match, lo_wrap, hi_wrap, lo_err, hi_err;

  int  cmp_cnt = 0;
  int  mis_cnt = 0;
  bit  chk_en  = 1'b0;
  st_t ma, mb;
  int  cv;

  param_binary_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_a (
    .clk_i(clk), .clr_i(clr), .sclr_i(sclr), .load_n_i(load_n), .d_i(d_a), .enp_i(enp),
    .ent_i(ent), .up_i(up), .cmp_i(cmp_a), .q_o(q_a), .rco_o(rco_a), .match_o(match_a),
    .wrap_o(wrap_a), .ld_err_o(err_a)
  );

  param_binary_counter #(.WIDTH(3), .MODULUS(5), .RESET_VAL(2)) u_b (
    .clk_i(clk), .clr_i(clr), .sclr_i(sclr), .load_n_i(load_n), .d_i(d_b), .enp_i(enp),
    .ent_i(ent), .up_i(up), .cmp_i(cmp_b), .q_o(q_b), .rco_o(rco_b), .match_o(match_b),
    .wrap_o(wrap_b), .ld_err_o(err_b)
  );

  param_binary_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_lo (
    .clk_i(clk), .clr_i(clr), .sclr_i(c_sclr), .load_n_i(c_load_n), .d_i(c_d[3:0]),
    .enp_i(c_enp), .ent_i(c_ent), .up_i(c_up), .cmp_i(c_cmp[3:0]), .q_o(lo_q),
    .rco_o(lo_rco), .match_o(lo_match), .wrap_o(lo_wrap), .ld_err_o(lo_err)
  );

  param_binary_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_hi (
    .clk_i(clk), .clr_i(clr), .sclr_i(c_sclr), .load_n_i(c_load_n), .d_i(c_d[7:4]),
    .enp_i(c_enp), .ent_i(lo_rco), .up_i(c_up), .cmp_i(c_cmp[7:4]), .q_o(hi_q),
    .rco_o(hi_rco), .match_o(hi_match), .wrap_o(hi_wrap), .ld_err_o(hi_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic st_t mstep(st_t s, int m, int r, logic sc, logic ldn, int d,
                                logic ep, logic et, logic u, int c);
    st_t n = s;
    n.wrap = 0;
    if (sc) begin
      n.q   = r;
      n.err = 0;
    end else if (!ldn) begin
      if (d < m) n.q = d;
      else begin
        n.q   = m - 1;
        n.err = 1;
      end
    end else if (ep && et) begin
      if (u) begin
        n.wrap = (s.q == m - 1) ? 1 : 0;
        n.q    = (s.q + 1) % m;
      end else begin
        n.wrap = (s.q == 0) ? 1 : 0;
        n.q    = (s.q + m - 1) % m;
      end
    end
    n.match = (n.q == c) ? 1 : 0;
    return n;
  endfunction

  function automatic int tc_of(int q, int m, logic u);
    return (u ? (q == m - 1) : (q == 0)) ? 1 : 0;
  endfunction

  // Reference model: whole-value arithmetic, cascade treated as one mod-256 counter.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      ma = '{q: 0, match: 0, wrap: 0, err: 0};
      mb = '{q: 2, match: 0, wrap: 0, err: 0};
      cv = 0;
    end else begin
      ma = mstep(ma, 10, 0, sclr, load_n, int'(d_a), enp, ent, up, int'(cmp_a));
      mb = mstep(mb, 5, 2, sclr, load_n, int'(d_b), enp, ent, up, int'(cmp_b));
      if (c_sclr) cv = 0;
      else if (!c_load_n) cv = int'(c_d);
      else if (c_enp && c_ent) cv = c_up ? (cv + 1) % 256 : (cv + 255) % 256;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_q", int'(q_a), ma.q);
      chk("a_match", int'(match_a), ma.match);
      chk("a_wrap", int'(wrap_a), ma.wrap);
      chk("a_lderr", int'(err_a), ma.err);
      chk("a_rco", int'(rco_a), int'(ent) * tc_of(ma.q, 10, up));
      chk("b_q", int'(q_b), mb.q);
      chk("b_match", int'(match_b), mb.match);
      chk("b_wrap", int'(wrap_b), mb.wrap);
      chk("b_lderr", int'(err_b), mb.err);
      chk("b_rco", int'(rco_b), int'(ent) * tc_of(mb.q, 5, up));
      chk("c_q", int'({hi_q, lo_q}), cv);
      chk("c_rco", int'(hi_rco), int'(c_ent) * tc_of(cv, 256, c_up));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    sclr = 0; load_n = 1; enp = 0; ent = 0; up = 1;
    d_a = 0; cmp_a = 4'd15; d_b = 0; cmp_b = 3'd7;
    c_sclr = 0; c_load_n = 1; c_enp = 0; c_ent = 0; c_up = 1; c_d = 0; c_cmp = 8'hFF;
    #1 clr = 1;
    #10;
    chk("rst_a_q", int'(q_a), 0);
    chk("rst_a_match", int'(match_a), 0);
    chk("rst_a_wrap", int'(wrap_a), 0);
    chk("rst_a_lderr", int'(err_a), 0);
    chk("rst_b_q", int'(q_b), 2);
    chk("rst_c_q", int'({hi_q, lo_q}), 0);
    clr = 0;
    tick();
    chk_en = 1'b1;

    // Count up through the wrap.
    enp = 1; ent = 1; up = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t1_q", int'(q_a), exp1[k]);
      chk("t1_wrap", int'(wrap_a), (k == 9) ? 1 : 0);
      chk("t1_rco", int'(rco_a), (k == 8) ? 1 : 0);
    end

    // Down from zero.
    enp = 0; sclr = 1;
    tick();
    sclr = 0; up = 0; enp = 1;
    #1 chk("t2_rco_at0", int'(rco_a), 1);
    tick();
    chk("t2_q", int'(q_a), 9);
    chk("t2_wrap", int'(wrap_a), 1);
    chk("t2_rco_at9", int'(rco_a), 0);
    enp = 0;
    tick();
    chk("t2_wrap_once", int'(wrap_a), 0);

    // Loads and sticky error.
    load_n = 0; d_a = 7;
    tick();
    chk("t3_q7", int'(q_a), 7);
    chk("t3_err7", int'(err_a), 0);
    d_a = 12;
    tick();
    chk("t3_q12", int'(q_a), 9);
    chk("t3_err12", int'(err_a), 1);
    d_a = 3;
    tick();
    chk("t3_q3", int'(q_a), 3);
    chk("t3_err3", int'(err_a), 1);
    load_n = 1; sclr = 1;
    tick();
    chk("t3_sclr_q", int'(q_a), 0);
    chk("t3_sclr_err", int'(err_a), 0);

    // Priority, then async clear between edges.
    load_n = 0; d_a = 5; enp = 1; ent = 1; up = 1;
    tick();
    chk("t4_prio", int'(q_a), 0);
    sclr = 0; load_n = 1;
    tick();
    tick();
    chk("t4_pre_clr", int'(q_a), 2);
    clr = 1;
    #1 chk("t4_async_q", int'(q_a), 0);
    clr = 0;

    // Enables and combinational RCO.
    load_n = 0; d_a = 9;
    tick();
    load_n = 1; enp = 0; ent = 1; up = 1;
    tick();
    chk("t5_hold_enp", int'(q_a), 9);
    chk("t5_rco", int'(rco_a), 1);
    ent = 0; enp = 1;
    #1 chk("t5_rco_ent0", int'(rco_a), 0);
    tick();
    chk("t5_hold_ent", int'(q_a), 9);
    load_n = 0; d_a = 0; ent = 1;
    tick();
    load_n = 1; enp = 0; up = 0;
    #1 chk("t5_rco_dn", int'(rco_a), 1);
    up = 1;
    #1 chk("t5_rco_up", int'(rco_a), 0);

    // Cascade into 8 bits.
    c_load_n = 0; c_d = 8'h0F;
    tick();
    c_load_n = 1; c_enp = 1; c_ent = 1; c_up = 1;
    tick();
    chk("t6_0f_10", int'({hi_q, lo_q}), 8'h10);
    c_load_n = 0; c_d = 8'hFF;
    tick();
    chk("t6_ff_rco", int'(hi_rco), 1);
    c_load_n = 1;
    tick();
    chk("t6_ff_00", int'({hi_q, lo_q}), 0);
    c_cmp = 8'h05; c_load_n = 0; c_d = 8'h03;
    tick();
    c_load_n = 1;
    tick();
    chk("t6_match4", int'(lo_match), 0);
    tick();
    chk("t6_q5", int'({hi_q, lo_q}), 5);
    chk("t6_match5", int'(lo_match), 1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      sclr     = ($urandom_range(0, 19) == 0);
      load_n   = ($urandom_range(0, 7) != 0);
      enp      = ($urandom_range(0, 3) != 0);
      ent      = ($urandom_range(0, 3) != 0);
      up       = 1'($urandom);
      d_a      = 4'($urandom);
      cmp_a    = 4'($urandom);
      d_b      = 3'($urandom);
      cmp_b    = 3'($urandom);
      c_sclr   = ($urandom_range(0, 29) == 0);
      c_load_n = ($urandom_range(0, 9) != 0);
      c_enp    = ($urandom_range(0, 3) != 0);
      c_ent    = ($urandom_range(0, 3) != 0);
      c_up     = ($urandom_range(0, 3) != 0);
      c_d      = 8'($urandom);
      c_cmp    = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        clr = 1;
        #1 clr = 0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
